lsu_mem_master: RTL and testbench

Initiator-side memory access sequencer for the npc core. It accepts one load or store at a time from the LSU over a valid/ready handshake, issues aligned 64-bit beats on the combinational DPI memory port, and splits accesses that cross an 8-byte boundary into two beats. For loads it assembles, shifts and sign/zero-extends the read data, and returns it on a response handshake. It sits between the EXU/LSU stage and the `pmem_read`/`pmem_write` memory model.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_align.sv | 48 ++++
 rtl/lsu_mem_master.sv | 168 ++++++++++++++++
 tb/tb_lsu_mem_master.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU memory master.
package lsu_pkg;

  localparam int unsigned XLEN      = 64;
  localparam int unsigned BEAT_BYTES = 8;

  localparam logic [XLEN-1:0] IDLE_ADDR_DEFAULT = 64'h8000_0000;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic            wen;
    size_e           size;
    logic            is_unsigned;
    logic [XLEN-1:0] wdata;
  } req_t;

endpackage

// File: rtl/lsu_align.sv
// Lane mask / store data alignment, split detect and load extract/extend.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]           off_i,
  input  size_e                size_i,
  input  logic                 unsigned_i,
  input  logic [XLEN-1:0]      wdata_i,
  input  logic [XLEN-1:0]      r0_i,
  input  logic [XLEN-1:0]      r1_i,
  output logic [2*BEAT_BYTES-1:0] mask16_o,
  output logic [2*XLEN-1:0]    data128_o,
  output logic                 split_o,
  output logic [XLEN-1:0]      load_o
);

  logic [3:0]      nbytes;
  logic [7:0]      lane_mask;
  logic [5:0]      shamt;
  logic [XLEN-1:0] rsh;
  logic            sx;

  always_comb begin
    case (size_i)
      SZ_B:    begin nbytes = 4'd1; lane_mask = 8'h01; end
      SZ_H:    begin nbytes = 4'd2; lane_mask = 8'h03; end
      SZ_W:    begin nbytes = 4'd4; lane_mask = 8'h0F; end
      default: begin nbytes = 4'd8; lane_mask = 8'hFF; end
    endcase

    shamt     = {off_i, 3'b000};
    split_o   = ({1'b0, off_i} + nbytes) > 4'd8;
    mask16_o  = 16'(lane_mask) << off_i;
    data128_o = 128'(wdata_i) << shamt;

    // r1 holds the upper beat; caller zeroes it for non-split accesses
    rsh = 64'({r1_i, r0_i} >> shamt);
    sx  = ~unsigned_i;

    case (size_i)
      SZ_B:    load_o = {{56{sx & rsh[7]}},  rsh[7:0]};
      SZ_H:    load_o = {{48{sx & rsh[15]}}, rsh[15:0]};
      SZ_W:    load_o = {{32{sx & rsh[31]}}, rsh[31:0]};
      default: load_o = rsh;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// LSU memory sequencer: one request at a time, one or two aligned 64-bit beats.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter logic [63:0] IDLE_ADDR = IDLE_ADDR_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic [63:0] mem_raddr,
  input  logic [63:0] mem_rdata,
  output logic [63:0] mem_waddr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask
);

  state_e          state_q, state_d;
  req_t            req_q, req_d;
  logic [XLEN-1:0] r0_q, r0_d;

  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic [XLEN-1:0] mem_raddr_q, mem_raddr_d;
  logic [XLEN-1:0] mem_waddr_q, mem_waddr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [7:0]      mem_wmask_q, mem_wmask_d;

  logic            hs;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] r0_sel, r1_sel;
  logic [15:0]     m16;
  logic [127:0]    d128;
  logic            split;
  logic [XLEN-1:0] load_res;

  assign hs = req_valid && req_ready_q;

  // Request fields as seen by the next cycle, so BEAT0 outputs can be registered at the handshake edge
  always_comb begin
    req_d = req_q;
    if (hs) begin
      req_d.addr        = req_addr;
      req_d.wen         = req_wen;
      req_d.size        = size_e'(req_size);
      req_d.is_unsigned = req_unsigned;
      req_d.wdata       = req_wdata;
    end
  end

  assign base   = {req_d.addr[63:3], 3'b000};
  assign r0_sel = (state_q == ST_BEAT0) ? mem_rdata : r0_q;
  assign r1_sel = (state_q == ST_BEAT1) ? mem_rdata : 64'h0;

  lsu_align u_align (
    .off_i      (req_d.addr[2:0]),
    .size_i     (req_d.size),
    .unsigned_i (req_d.is_unsigned),
    .wdata_i    (req_d.wdata),
    .r0_i       (r0_sel),
    .r1_i       (r1_sel),
    .mask16_o   (m16),
    .data128_o  (d128),
    .split_o    (split),
    .load_o     (load_res)
  );

  always_comb begin
    state_d      = state_q;
    r0_d         = r0_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    mem_raddr_d  = IDLE_ADDR;
    mem_waddr_d  = '0;
    mem_wdata_d  = '0;
    mem_wmask_d  = '0;

    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          state_d     = ST_BEAT0;
          mem_raddr_d = base;
          if (req_d.wen) begin
            mem_waddr_d = base;
            mem_wmask_d = m16[7:0];
            mem_wdata_d = d128[63:0];
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      ST_BEAT0: begin
        r0_d = mem_rdata;
        if (split) begin
          state_d     = ST_BEAT1;
          mem_raddr_d = base + 64'd8;
          if (req_d.wen) begin
            mem_waddr_d = base + 64'd8;
            mem_wmask_d = m16[15:8];
            mem_wdata_d = d128[127:64];
          end
        end else begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = req_d.wen ? 64'h0 : load_res;
        end
      end
      ST_BEAT1: begin
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = req_d.wen ? 64'h0 : load_res;
      end
      default: begin
        if (resp_ready) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
        end else begin
          resp_valid_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      r0_q         <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      mem_raddr_q  <= IDLE_ADDR;
      mem_waddr_q  <= '0;
      mem_wdata_q  <= '0;
      mem_wmask_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      r0_q         <= r0_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      mem_raddr_q  <= mem_raddr_d;
      mem_waddr_q  <= mem_waddr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wmask_q  <= mem_wmask_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_raddr  = mem_raddr_q;
  assign mem_waddr  = mem_waddr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wmask  = mem_wmask_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master against a small byte-addressed memory model.
module tb_lsu_mem_master;

  localparam logic [63:0] IDLE = 64'h8000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        preload = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = '0;
  logic        req_wen = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [63:0] resp_rdata;
  logic [63:0] mem_raddr;
  logic [63:0] mem_rdata;
  logic [63:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;

  lsu_mem_master dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_wen      (req_wen),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .mem_raddr    (mem_raddr),
    .mem_rdata    (mem_rdata),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int rd_beats = 0;
  int done_cnt = 0;

  typedef struct { logic [63:0] data; int cyc; } resp_exp_t;
  typedef struct { logic [63:0] addr; logic [7:0] mask; logic [63:0] data; } wr_exp_t;
  resp_exp_t rq[$];
  wr_exp_t   wq[$];

  // Memory model: 64 words from IDLE, combinational read, byte-masked write
  logic [63:0] mem [0:63];
  logic rd_in, wr_in;
  assign rd_in = (mem_raddr >= IDLE) && (mem_raddr < IDLE + 64'h200);
  assign wr_in = (mem_waddr >= IDLE) && (mem_waddr < IDLE + 64'h200);
  assign mem_rdata = rd_in ? mem[mem_raddr[8:3]] : 64'h0;

  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 64'h0;
      mem[0] <= 64'h0000_0000_8000_0000;
      mem[2] <= 64'h1122_3344_5566_7788;
      mem[3] <= 64'hA5A5_A5A5_A5A5_A5A5;
    end else if (mem_wmask != 8'h00 && wr_in) begin
      for (int b = 0; b < 8; b++)
        if (mem_wmask[b]) mem[mem_waddr[8:3]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: write beats, idle-output rules and responses
  logic      in_resp = 1'b0;
  logic [63:0] held = '0;
  always @(negedge clock) begin
    if (mem_wmask != 8'h00) begin
      if (wq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: addr %h mask %h data %h", mem_waddr, mem_wmask, mem_wdata);
      end else begin
        wr_exp_t w;
        w = wq.pop_front();
        chk("wr_addr", mem_waddr, w.addr);
        chk("wr_mask", 64'(mem_wmask), 64'(w.mask));
        chk("wr_data", mem_wdata, w.data);
      end
    end else begin
      chk("idle_waddr", mem_waddr, 64'h0);
      chk("idle_wdata", mem_wdata, 64'h0);
    end
    if (mem_raddr != IDLE) rd_beats++;
    if (reset) begin
      in_resp = 1'b0;
    end else if (resp_valid) begin
      chk("resp_req_ready", 64'(req_ready), 64'h0);
      chk("resp_raddr", mem_raddr, IDLE);
      if (!in_resp) begin
        in_resp = 1'b1;
        held    = resp_rdata;
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: data %h", resp_rdata);
        end else begin
          resp_exp_t e;
          e = rq.pop_front();
          chk("resp_rdata", resp_rdata, e.data);
          chk("resp_cycle", 64'(cyc), 64'(e.cyc));
        end
      end else begin
        chk("resp_hold", resp_rdata, held);
      end
      if (resp_ready) begin
        in_resp = 1'b0;
        done_cnt++;
      end
    end
  end

  task automatic issue(input logic [63:0] addr, input logic wen, input logic [1:0] size,
                       input logic uns, input logic [63:0] wdata,
                       input logic [63:0] exp_rdata, input int lat, input bit want_resp);
    int n = 0;
    @(negedge clock);
    req_addr = addr; req_wen = wen; req_size = size; req_unsigned = uns; req_wdata = wdata;
    req_valid = 1'b1;
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_timeout: req_ready=%0b addr %h", req_ready, addr);
      req_valid = 1'b0;
      return;
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    if (want_resp) rq.push_back('{exp_rdata, cyc + lat - 1});
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (done_cnt < target) begin
      checks++; errors++;
      $display("FAIL resp_timeout: done %0d expected %0d", done_cnt, target);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'h1);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'h0);
    chk({tag, "_resp_rdata"}, resp_rdata, 64'h0);
    chk({tag, "_wmask"}, 64'(mem_wmask), 64'h0);
    chk({tag, "_wdata"}, mem_wdata, 64'h0);
    chk({tag, "_waddr"}, mem_waddr, 64'h0);
    chk({tag, "_raddr"}, mem_raddr, IDLE);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation stuck at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_done = 0;
    int b0;
    @(posedge clock); #1;
    check_reset_vals("reset");
    @(posedge clock); #1;
    preload = 1'b0;
    reset   = 1'b0;

    // Aligned LD, one read beat
    b0 = rd_beats;
    issue(64'h8000_0010, 1'b0, 2'd3, 1'b0, 64'h0, 64'h1122_3344_5566_7788, 2, 1'b1);
    wait_done(++exp_done);
    chk("ld_read_beats", 64'(rd_beats - b0), 64'd1);

    // LB signed / unsigned of 0x80
    issue(64'h8000_0003, 1'b0, 2'd0, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 2, 1'b1);
    wait_done(++exp_done);
    issue(64'h8000_0003, 1'b0, 2'd0, 1'b1, 64'h0, 64'h0000_0000_0000_0080, 2, 1'b1);
    wait_done(++exp_done);

    // SH at the top of a beat, not split
    wq.push_back('{64'h8000_0000, 8'hC0, 64'hBEEF_0000_0000_0000});
    issue(64'h8000_0006, 1'b1, 2'd1, 1'b0, 64'h0000_0000_0000_BEEF, 64'h0, 2, 1'b1);
    wait_done(++exp_done);

    // Split SW across the 8-byte boundary
    wq.push_back('{64'h8000_0000, 8'hC0, 64'hBEEF_0000_0000_0000});
    wq.push_back('{64'h8000_0008, 8'h03, 64'h0000_0000_0000_DEAD});
    issue(64'h8000_0006, 1'b1, 2'd2, 1'b0, 64'h0000_0000_DEAD_BEEF, 64'h0, 3, 1'b1);
    wait_done(++exp_done);

    // Readbacks: split LW/LWU/LH, non-split LHU
    issue(64'h8000_0006, 1'b0, 2'd2, 1'b0, 64'h0, 64'hFFFF_FFFF_DEAD_BEEF, 3, 1'b1);
    wait_done(++exp_done);
    issue(64'h8000_0006, 1'b0, 2'd2, 1'b1, 64'h0, 64'h0000_0000_DEAD_BEEF, 3, 1'b1);
    wait_done(++exp_done);
    issue(64'h8000_0006, 1'b0, 2'd1, 1'b1, 64'h0, 64'h0000_0000_0000_BEEF, 2, 1'b1);
    wait_done(++exp_done);
    issue(64'h8000_0007, 1'b0, 2'd1, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_ADBE, 3, 1'b1);
    wait_done(++exp_done);

    // Response backpressure: hold resp_ready low for 5 cycles
    resp_ready = 1'b0;
    issue(64'h8000_0018, 1'b0, 2'd3, 1'b0, 64'h0, 64'hA5A5_A5A5_A5A5_A5A5, 2, 1'b1);
    begin
      int n = 0;
      while (!resp_valid && n < 10) begin
        @(posedge clock); #1;
        n++;
      end
    end
    b0 = rd_beats;
    repeat (4) begin
      @(posedge clock); #1;
    end
    resp_ready = 1'b1;
    wait_done(++exp_done);
    chk("stall_read_beats", 64'(rd_beats - b0), 64'd0);

    // Reset during BEAT0 of a split SD: beat0 lands, beat1 must never appear
    wq.push_back('{64'h8000_0010, 8'hF0, 64'h0506_0708_0000_0000});
    issue(64'h8000_0014, 1'b1, 2'd3, 1'b0, 64'h0102_0304_0506_0708, 64'h0, 3, 1'b0);
    reset = 1'b1;
    @(posedge clock); #1;
    check_reset_vals("midrst");
    reset = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
    end
    chk("midrst_resp_valid", 64'(resp_valid), 64'h0);

    issue(64'h8000_0010, 1'b0, 2'd3, 1'b0, 64'h0, 64'h0506_0708_5566_7788, 2, 1'b1);
    wait_done(++exp_done);
    issue(64'h8000_0018, 1'b0, 2'd3, 1'b0, 64'h0, 64'hA5A5_A5A5_A5A5_A5A5, 2, 1'b1);
    wait_done(++exp_done);

    repeat (2) @(posedge clock);
    #1;
    chk("wq_drained", 64'(wq.size()), 64'h0);
    chk("rq_drained", 64'(rq.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
